// File: rtl/adder_flit_arbiter_if.sv
// Flit request bus and result port shared between packet injectors and adder_flit_arbiter.
// master = injector/downstream side, slave = arbiter side.
interface adder_flit_arbiter_if #(
  parameter int N    = 26,
  parameter int NREQ = 4,
  parameter int IDW  = 2
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [NREQ*N-1:0] req_in1;
  logic [NREQ*N-1:0] req_in2;
  logic [NREQ-1:0]   req_ready;

  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      out_sum;
  logic              out_carry;
  logic [IDW-1:0]    out_id;
  logic              out_last;

  modport master (
    output req_valid, req_last, req_in1, req_in2, out_ready,
    input  req_ready, out_valid, out_sum, out_carry, out_id, out_last
  );

  modport slave (
    input  req_valid, req_last, req_in1, req_in2, out_ready,
    output req_ready, out_valid, out_sum, out_carry, out_id, out_last
  );

endinterface

// File: rtl/adder_flit_arbiter.sv
// Packet-granular round-robin arbiter sharing one N-bit adder among NREQ flit sources.
// Define ADDER_ACTIVITY_CNT_EN to add saturating busy/stall cycle counters.
module adder_flit_arbiter #(
  parameter int N    = 26,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  adder_flit_arbiter_if.slave io_bus
`ifdef ADDER_ACTIVITY_CNT_EN
  ,
  output logic [31:0]         o_busy_cycles,
  output logic [31:0]         o_stall_cycles
`endif
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  w_rr_ptr_nxt;
  logic [IDW-1:0]  r_owner;
  logic [IDW-1:0]  w_owner_nxt;

  logic            r_out_valid;
  logic [N-1:0]    r_out_sum;
  logic            r_out_carry;
  logic [IDW-1:0]  r_out_id;
  logic            r_out_last;

  logic            w_space;
  logic            w_found;
  logic [IDW-1:0]  w_search;
  logic            w_cand;
  logic [IDW-1:0]  w_sel;
  logic [IDW-1:0]  w_sel_inc;
  logic            w_sel_valid;
  logic            w_sel_last;
  logic [N-1:0]    w_op1;
  logic [N-1:0]    w_op2;
  logic [N:0]      w_sum;
  logic            w_accept;
  logic [NREQ-1:0] w_ready;

  assign w_space = !r_out_valid || io_bus.out_ready;

  // First valid requester at or after the round-robin pointer, wrapping modulo NREQ.
  always_comb begin
    w_found  = 1'b0;
    w_search = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!w_found && (k == (int'(r_rr_ptr) + i) % NREQ) && io_bus.req_valid[k]) begin
          w_found  = 1'b1;
          w_search = IDW'(k);
        end
      end
    end
  end

  assign w_sel     = (r_state == LOCKED) ? r_owner : w_search;
  assign w_cand    = (r_state == LOCKED) ? 1'b1 : w_found;
  assign w_sel_inc = (w_sel == IDW'(NREQ - 1)) ? '0 : w_sel + 1'b1;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_op1       = '0;
    w_op2       = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_sel == IDW'(k)) begin
        w_sel_valid = io_bus.req_valid[k];
        w_sel_last  = io_bus.req_last[k];
        w_op1       = io_bus.req_in1[k*N +: N];
        w_op2       = io_bus.req_in2[k*N +: N];
      end
    end
  end

  assign w_sum = {1'b0, w_op1} + {1'b0, w_op2};

  // A locked owner is offered ready even while idle inside its packet, so others stay stalled.
  always_comb begin
    w_ready      = '0;
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      w_ready[k] = w_cand && w_space && (w_sel == IDW'(k));
    end
    w_accept = w_cand && w_space && w_sel_valid;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_sel_last) begin
            w_rr_ptr_nxt = w_sel_inc;
          end else begin
            w_state_nxt = LOCKED;
            w_owner_nxt = w_sel;
          end
        end
      end
      LOCKED: begin
        if (w_accept && w_sel_last) begin
          w_state_nxt  = IDLE;
          w_rr_ptr_nxt = w_sel_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_owner  <= w_owner_nxt;
    end
  end

  // Data registers only load on accept and otherwise hold, keeping toggle activity low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_carry <= 1'b0;
      r_out_id    <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_sum[N-1:0];
      r_out_carry <= w_sum[N];
      r_out_id    <= w_sel;
      r_out_last  <= w_sel_last;
    end else if (r_out_valid && io_bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign io_bus.req_ready = w_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_sum   = r_out_sum;
  assign io_bus.out_carry = r_out_carry;
  assign io_bus.out_id    = r_out_id;
  assign io_bus.out_last  = r_out_last;

`ifdef ADDER_ACTIVITY_CNT_EN
  logic [31:0] r_busy_cycles;
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy_cycles  <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (w_accept && (r_busy_cycles != 32'hFFFF_FFFF)) begin
        r_busy_cycles <= r_busy_cycles + 32'd1;
      end
      if ((|io_bus.req_valid) && !w_accept && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  assign o_busy_cycles  = r_busy_cycles;
  assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_adder_flit_arbiter.sv
// Bench for adder_flit_arbiter: directed vector table, hand sequences and random traffic
// checked against a packet-level reference model.
module tb_adder_flit_arbiter;

  localparam int N    = 26;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  adder_flit_arbiter_if #(.N(N), .NREQ(NREQ), .IDW(IDW)) bus ();

`ifdef ADDER_ACTIVITY_CNT_EN
  logic [31:0] busyCycles;
  logic [31:0] stallCycles;
`endif

  adder_flit_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk            (clk),
    .rst            (rst),
    .io_bus         (bus)
`ifdef ADDER_ACTIVITY_CNT_EN
    ,
    .o_busy_cycles  (busyCycles),
    .o_stall_cycles (stallCycles)
`endif
  );

  int nCompared   = 0;
  int nMismatched = 0;

  bit             checkEn = 1'b0;
  bit             mLocked = 1'b0;
  int             mOwner  = 0;
  int             mPtr    = 0;
  logic           eValid  = 1'b0;
  logic [N-1:0]   eSum    = '0;
  logic           eCarry  = 1'b0;
  logic [IDW-1:0] eId     = '0;
  logic           eLast   = 1'b0;
  logic [31:0]    eBusy   = '0;
  logic [31:0]    eStall  = '0;
  logic [NREQ-1:0] lastReady;

  typedef struct {
    int           src;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] sum;
    logic         carry;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] oneHot(input int k);
    logic [NREQ-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Reference model: a packet-level view of who owns the adder and what the result port should hold.
  task automatic modelStep();
    int              sel;
    bit              cand;
    bit              space;
    bit              acc;
    logic [NREQ-1:0] expReady;
    logic [N:0]      full;
    if (checkEn) begin
      checkOutput("out_valid", 64'(bus.out_valid), 64'(eValid));
      checkOutput("out_sum", 64'(bus.out_sum), 64'(eSum));
      checkOutput("out_carry", 64'(bus.out_carry), 64'(eCarry));
      checkOutput("out_id", 64'(bus.out_id), 64'(eId));
      checkOutput("out_last", 64'(bus.out_last), 64'(eLast));
`ifdef ADDER_ACTIVITY_CNT_EN
      checkOutput("busy_cycles", 64'(busyCycles), 64'(eBusy));
      checkOutput("stall_cycles", 64'(stallCycles), 64'(eStall));
`endif
    end
    space = !eValid || bus.out_ready;
    cand  = 1'b0;
    sel   = 0;
    if (mLocked) begin
      cand = 1'b1;
      sel  = mOwner;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!cand && bus.req_valid[(mPtr + i) % NREQ]) begin
          cand = 1'b1;
          sel  = (mPtr + i) % NREQ;
        end
      end
    end
    expReady = (cand && space) ? oneHot(sel) : '0;
    if (checkEn) checkOutput("req_ready", 64'(bus.req_ready), 64'(expReady));
    lastReady = bus.req_ready;
    acc = cand && space && bus.req_valid[sel];
    if (rst) begin
      mLocked = 1'b0; mOwner = 0; mPtr = 0;
      eValid = 1'b0; eSum = '0; eCarry = 1'b0; eId = '0; eLast = 1'b0;
      eBusy = '0; eStall = '0;
    end else begin
      if (acc) begin
        full   = {1'b0, bus.req_in1[sel*N +: N]} + {1'b0, bus.req_in2[sel*N +: N]};
        eSum   = full[N-1:0];
        eCarry = full[N];
        eId    = IDW'(sel);
        eLast  = bus.req_last[sel];
        eValid = 1'b1;
        if (bus.req_last[sel]) begin
          mLocked = 1'b0;
          mPtr    = (sel + 1) % NREQ;
        end else begin
          mLocked = 1'b1;
          mOwner  = sel;
        end
      end else if (eValid && bus.out_ready) begin
        eValid = 1'b0;
      end
      if (acc && eBusy != 32'hFFFF_FFFF) eBusy++;
      if ((|bus.req_valid) && !acc && eStall != 32'hFFFF_FFFF) eStall++;
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int k, input logic v, input logic l, input logic [N-1:0] a, input logic [N-1:0] b);
    bus.req_valid[k]       = v;
    bus.req_last[k]        = l;
    bus.req_in1[k*N +: N]  = a;
    bus.req_in2[k*N +: N]  = b;
  endtask

  task automatic clearReqs();
    for (int k = 0; k < NREQ; k++) setReq(k, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{src: 0, a: 26'h0000001, b: 26'h0000002, sum: 26'h0000003, carry: 1'b0};
    vecs[1] = '{src: 0, a: 26'h3FFFFFF, b: 26'h0000001, sum: 26'h0000000, carry: 1'b1};
    vecs[2] = '{src: 1, a: 26'h3FFFFFF, b: 26'h3FFFFFF, sum: 26'h3FFFFFE, carry: 1'b1};
    vecs[3] = '{src: 2, a: 26'h1234567, b: 26'h0ABCDEF, sum: 26'h1CF1356, carry: 1'b0};
    vecs[4] = '{src: 3, a: 26'h2000000, b: 26'h2000000, sum: 26'h0000000, carry: 1'b1};
    vecs[5] = '{src: 1, a: 26'h0000000, b: 26'h0000000, sum: 26'h0000000, carry: 1'b0};

    clearReqs();
    bus.out_ready = 1'b1;
    doReset();
    checkEn = 1'b1;
    checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset out_sum", 64'(bus.out_sum), 64'd0);
    checkOutput("reset out_id", 64'(bus.out_id), 64'd0);

    for (int i = 0; i < 6; i++) begin
      clearReqs();
      setReq(vecs[i].src, 1'b1, 1'b1, vecs[i].a, vecs[i].b);
      applyStimulus();
      clearReqs();
      checkOutput("vec ready", 64'(lastReady), 64'(oneHot(vecs[i].src)));
      checkOutput("vec valid", 64'(bus.out_valid), 64'd1);
      checkOutput("vec sum", 64'(bus.out_sum), 64'(vecs[i].sum));
      checkOutput("vec carry", 64'(bus.out_carry), 64'(vecs[i].carry));
      checkOutput("vec id", 64'(bus.out_id), 64'(vecs[i].src));
      checkOutput("vec last", 64'(bus.out_last), 64'd1);
    end

    // Packet lock: requester 1 keeps the adder for 20 flits while requester 2 waits.
    doReset();
    clearReqs();
    setReq(2, 1'b1, 1'b1, 26'd7, 26'd8);
    for (int f = 0; f < 20; f++) begin
      setReq(1, 1'b1, (f == 19), N'(f), 26'd100);
      applyStimulus();
      checkOutput("lock ready", 64'(lastReady), 64'(oneHot(1)));
      checkOutput("lock id", 64'(bus.out_id), 64'd1);
      checkOutput("lock last", 64'(bus.out_last), 64'(f == 19));
      checkOutput("lock sum", 64'(bus.out_sum), 64'(f + 100));
    end
    setReq(1, 1'b0, 1'b0, '0, '0);
    applyStimulus();
    checkOutput("lock next id", 64'(bus.out_id), 64'd2);
    checkOutput("lock next sum", 64'(bus.out_sum), 64'd15);

    // Round-robin over single-flit packets from all requesters.
    doReset();
    for (int k = 0; k < NREQ; k++) setReq(k, 1'b1, 1'b1, N'(k), 26'h100);
    for (int c = 0; c < 12; c++) begin
      applyStimulus();
      checkOutput("rr valid", 64'(bus.out_valid), 64'd1);
      checkOutput("rr id", 64'(bus.out_id), 64'(c % NREQ));
    end

    // Backpressure mid-packet from requester 0.
    clearReqs();
    setReq(0, 1'b1, 1'b0, 26'd10, 26'd5);
    applyStimulus();
    setReq(0, 1'b1, 1'b0, 26'd11, 26'd5);
    applyStimulus();
    bus.out_ready = 1'b0;
    setReq(0, 1'b1, 1'b0, 26'd12, 26'd5);
    for (int c = 0; c < 3; c++) begin
      applyStimulus();
      checkOutput("bp ready", 64'(lastReady), 64'd0);
      checkOutput("bp valid", 64'(bus.out_valid), 64'd1);
      checkOutput("bp sum", 64'(bus.out_sum), 64'd16);
    end
    bus.out_ready = 1'b1;
    applyStimulus();
    checkOutput("bp resume sum", 64'(bus.out_sum), 64'd17);

    // Gap inside the packet: requester 1 must not sneak in.
    setReq(0, 1'b0, 1'b0, '0, '0);
    setReq(1, 1'b1, 1'b1, 26'd50, 26'd60);
    for (int c = 0; c < 7; c++) begin
      applyStimulus();
      checkOutput("gap ready", 64'(lastReady), 64'(oneHot(0)));
      checkOutput("gap id", 64'(bus.out_id), 64'd0);
    end
    setReq(0, 1'b1, 1'b1, 26'd13, 26'd5);
    applyStimulus();
    checkOutput("gap end sum", 64'(bus.out_sum), 64'd18);
    checkOutput("gap end last", 64'(bus.out_last), 64'd1);
    setReq(0, 1'b0, 1'b0, '0, '0);
    applyStimulus();
    checkOutput("gap next id", 64'(bus.out_id), 64'd1);
    checkOutput("gap next sum", 64'(bus.out_sum), 64'd110);

    // Reset while requester 3 owns the adder.
    doReset();
    clearReqs();
    setReq(3, 1'b1, 1'b0, 26'd1, 26'd1);
    applyStimulus();
    applyStimulus();
    setReq(1, 1'b1, 1'b1, 26'd20, 26'd22);
    setReq(2, 1'b1, 1'b1, 26'd1, 26'd2);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    checkOutput("rst out_valid", 64'(bus.out_valid), 64'd0);
    setReq(2, 1'b0, 1'b0, '0, '0);
    applyStimulus();
    checkOutput("rst grant ready", 64'(lastReady), 64'(oneHot(1)));
    checkOutput("rst grant id", 64'(bus.out_id), 64'd1);
    checkOutput("rst grant sum", 64'(bus.out_sum), 64'd42);

`ifdef ADDER_ACTIVITY_CNT_EN
    doReset();
    clearReqs();
    setReq(0, 1'b1, 1'b1, 26'd1, 26'd1);
    for (int c = 0; c < 5; c++) applyStimulus();
    clearReqs();
    applyStimulus();
    checkOutput("cnt busy", 64'(busyCycles), 64'd5);
    checkOutput("cnt stall", 64'(stallCycles), 64'd0);
`endif

    // Random traffic against the reference model.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if ($urandom_range(0, 7) == 0)
          setReq(k, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), '1, N'($urandom));
        else
          setReq(k, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), N'($urandom), N'($urandom));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus();
    end
    rst = 1'b0;
    clearReqs();
    applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
